// File: rtl/ccx_mem_rsp.sv
// Core-complex memory responder: range-checks bus requests, drives a single-port SRAM
// and returns in-order responses through a small FIFO. Optional write protect: CCX_MEM_RSP_WPROT_EN.
module ccx_mem_rsp #(
   parameter int              AW        = 39,
   parameter int              DW        = 64,
   parameter logic [AW-1:0]   BASE      = 39'h00010000,
   parameter logic [AW-1:0]   SIZE      = 39'h0000FFFF,
   parameter int              DEPTH     = 8192,
   parameter int              RSP_DEPTH = 4,
   localparam int             SAW       = $clog2(DEPTH)
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              mem_req,
   output logic              mem_gnt,
   input  logic              mem_wen,
   input  logic [DW/8-1:0]   mem_strb,
   input  logic [AW-1:0]     mem_addr,
   input  logic [DW-1:0]     mem_wdata,
`ifdef CCX_MEM_RSP_WPROT_EN
   input  logic              mem_wprot,
`endif
   output logic              mem_ack,
   input  logic              mem_recv,
   output logic [DW-1:0]     mem_rdata,
   output logic              mem_error,
   output logic              sram_cen,
   output logic              sram_wen,
   output logic [DW/8-1:0]   sram_strb,
   output logic [SAW-1:0]    sram_addr,
   output logic [DW-1:0]     sram_wdata,
   input  logic [DW-1:0]     sram_rdata
);

   localparam int              OB       = $clog2(DW/8);
   localparam int              PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int              CW       = $clog2(RSP_DEPTH + 1);
   localparam logic [CW:0]     DEPTH_C  = (CW+1)'(RSP_DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(RSP_DEPTH - 1);

   logic [AW-1:0] offset;
   logic          addrHit;
   logic          wprotHit;
   logic          accept;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic [DW-1:0] pushData;

   logic          s1Valid_q, s1Valid_d;
   logic          s1Read_q,  s1Read_d;
   logic          s1Err_q,   s1Err_d;
   logic [CW-1:0] count_q,   count_d;
   logic [PW-1:0] wrPtr_q,   wrPtr_d;
   logic [PW-1:0] rdPtr_q,   rdPtr_d;
   logic [DW-1:0] fifoData_q [RSP_DEPTH];
   logic          fifoErr_q  [RSP_DEPTH];

   assign offset  = mem_addr - BASE;
   assign addrHit = (mem_addr >= BASE) && (offset <= SIZE);

`ifdef CCX_MEM_RSP_WPROT_EN
   assign wprotHit = mem_wen && mem_wprot;
`else
   assign wprotHit = 1'b0;
`endif

   // The access in stage 1 is counted so its response always has a FIFO slot.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, s1Valid_q};
   assign mem_gnt   = g_resetn && (occupancy < DEPTH_C);
   assign accept    = mem_req && mem_gnt;

   assign sram_cen   = accept && addrHit && !wprotHit;
   assign sram_wen   = sram_cen && mem_wen;
   assign sram_strb  = sram_wen ? mem_strb : '0;
   assign sram_addr  = SAW'(offset >> OB);
   assign sram_wdata = mem_wdata;

   always_comb begin
      s1Valid_d = accept;
      s1Read_d  = !mem_wen;
      s1Err_d   = !addrHit || wprotHit;
   end

   assign push     = s1Valid_q;
   assign pop      = (count_q != '0) && mem_recv;
   assign pushData = (s1Read_q && !s1Err_q) ? sram_rdata : '0;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PW'(1);
      end
      if (pop) begin
         rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         s1Valid_q <= 1'b0;
         s1Read_q  <= 1'b0;
         s1Err_q   <= 1'b0;
         count_q   <= '0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
      end else begin
         s1Valid_q <= s1Valid_d;
         s1Read_q  <= s1Read_d;
         s1Err_q   <= s1Err_d;
         count_q   <= count_d;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
      end
   end

   // Storage needs no reset: outputs are masked whenever the FIFO is empty.
   always_ff @(posedge g_clk) begin
      if (push) begin
         fifoData_q[wrPtr_q] <= pushData;
         fifoErr_q[wrPtr_q]  <= s1Err_q;
      end
   end

   assign mem_ack   = (count_q != '0);
   assign mem_rdata = mem_ack ? fifoData_q[rdPtr_q] : '0;
   assign mem_error = mem_ack && fifoErr_q[rdPtr_q];

endmodule

// File: doc/ccx_mem_rsp.md
Name: ccx_mem_rsp

Overview:
- Core-complex memory responder: the target end of a core_mem_bus.
- Accepts requests from an interconnect arbiter port (ROM/RAM target) and drives a single-port synchronous SRAM macro.
- Returns in-order responses through a buffered response channel.
- Checks the address range and returns an error for out-of-range accesses without touching the SRAM.

Parameters:
- AW, 39, address width.
- DW, 64, data width; byte-strobe width is DW/8.
- BASE, 39'h00010000, first byte address served.
- SIZE, 39'h0000FFFF, last valid byte offset from BASE (inclusive).
- DEPTH, 8192, SRAM depth in DW-bit words; SAW = $clog2(DEPTH).
- RSP_DEPTH, 4, response FIFO entries; minimum 1.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  asynchronous active-low reset.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted this cycle (req && gnt).
- mem_wen  in  1  1=write, 0=read.
- mem_strb  in  DW/8  write byte strobes.
- mem_addr  in  AW  byte address.
- mem_wdata  in  DW  write data.
- mem_ack  out  1  response valid.
- mem_recv  in  1  requester accepts response (ack && recv).
- mem_rdata  out  DW  read data; 0 for writes and errors.
- mem_error  out  1  response is an error.
- sram_cen  out  1  SRAM access enable.
- sram_wen  out  1  SRAM write enable.
- sram_strb  out  DW/8  SRAM byte write enables.
- sram_addr  out  SAW  SRAM word index.
- sram_wdata  out  DW  SRAM write data.
- sram_rdata  in  DW  SRAM read data; valid the cycle after a read access.

Behaviour:
- Reset (async, g_resetn=0):
  - FIFO count=0, s1_valid=0.
  - mem_ack=0, mem_rdata=0, mem_error=0.
  - sram_cen=0, sram_wen=0.
  - All in-flight accesses and queued responses are discarded.
  - mem_gnt=0 while in reset.
- Grant:
  - mem_gnt = (count + s1_valid) < RSP_DEPTH; combinational, independent of mem_req.
  - Full throughput needs RSP_DEPTH >= 3.
- Range check: hit = (mem_addr >= BASE) && (mem_addr - BASE <= SIZE); subtraction is done at AW width.
- Word index: sram_addr = (mem_addr - BASE) >> log2(DW/8), truncated to SAW; low address bits are ignored (no alignment error).
- Accept cycle T (req && gnt):
  - If hit: sram_cen=1, sram_wen=mem_wen, sram_strb=mem_strb, sram_wdata=mem_wdata. sram_cen is combinational from accept.
  - If miss: sram_cen=0.
- Stage 1 (T+1):
  - s1_valid=1; stage 1 holds {is_read, err}.
  - Entry pushed into the FIFO at the end of T+1:
    - read hit: rdata=sram_rdata, error=0.
    - write hit: rdata=0, error=0.
    - miss: rdata=0, error=1.
- Response (T+2 earliest):
  - mem_ack=1 whenever count>0.
  - mem_rdata and mem_error come from the FIFO head.
  - Pop on mem_ack && mem_recv.
  - Fixed minimum latency: 2 cycles from accept to ack for every request type.
- Ordering: strictly in order; at most one SRAM access per cycle.
- Response stability: while mem_ack=1 and mem_recv=0, mem_ack, mem_rdata and mem_error are held stable.
- Simultaneous push and pop in one cycle: count unchanged; the FIFO wraps its read and write pointers modulo RSP_DEPTH.
- Full: count + s1_valid == RSP_DEPTH forces gnt=0; no push is ever dropped.
- Empty: mem_ack=0; mem_rdata and mem_error hold 0.
- Read-after-write to the same word on consecutive accepts returns the new data (the SRAM write completes at the end of T).

Optional Feature:
- Macro: CCX_MEM_RSP_WPROT_EN.
- When defined: a write-protect input port mem_wprot (1 bit) is added.
  - A write accepted while mem_wprot=1 and in range does not assert sram_cen.
  - It returns error=1, rdata=0 with the same 2-cycle latency.
  - Reads are unaffected.
- When undefined: the port is absent and in-range writes always proceed.

Test Plan:
- Reset, then read 0x00010008 with recv=1 → gnt same cycle; sram_cen=1, sram_addr=1 at T; ack at T+2 with rdata=SRAM word 1, error=0.
- Write 0x00010010, strb=8'h0F, wdata=64'hAAAA_BBBB_CCCC_DDDD, then read the same address next cycle → write ack with rdata=0, error=0; read returns low 4 bytes CCCC_DDDD merged with the prior upper bytes.
- Read 0x00020000 (out of range) → sram_cen=0; ack at T+2 with error=1, rdata=0.
- mem_recv=0, 5 back-to-back reads, RSP_DEPTH=4 → exactly 4 grants, then gnt=0. Raise recv → 4 acks in address order, gnt returns, 5th read completes.
- Continuous reads with recv=1 → one ack per cycle after a 2-cycle fill; count never exceeds 1.
- Assert g_resetn=0 with 2 queued responses → mem_ack=0 immediately. After release, the next read gets ack at T+2 with no stale data.
- With CCX_MEM_RSP_WPROT_EN defined: wprot=1, write 0x00010000 → sram_cen=0, error=1. Then wprot=0, read 0x00010000 → original data.
